// File: rtl/dsp48a1_pkg.sv
// rtl/dsp48a1_pkg.sv - shared widths, OPMODE fields and post-adder helper for the DSP48A1 slice
//
// Purpose: constants and types used by the post-adder stage and its pipeline registers.
//   - operand widths (P/C/PCIN, M, A/B, D)
//   - OPMODE bit positions owned by the post-adder
//   - X and Z multiplexer select encodings
//   - post_add(): 49-bit add/subtract producing {carry, result}
package dsp48a1_pkg;

   localparam int P_W  = 48;
   localparam int M_W  = 36;
   localparam int AB_W = 18;
   localparam int D_W  = 12;

   localparam int OP_X_LSB = 0;
   localparam int OP_Z_LSB = 2;
   localparam int OP_CIN   = 5;
   localparam int OP_SUB   = 7;

   typedef enum logic [1:0] {
      X_ZERO = 2'd0,
      X_M    = 2'd1,
      X_P    = 2'd2,
      X_DAB  = 2'd3
   } x_sel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'd0,
      Z_PCIN = 2'd1,
      Z_P    = 2'd2,
      Z_C    = 2'd3
   } z_sel_e;

   // Bit 48 of the result is the carry for addition and the borrow for
   // subtraction; both operands are zero-extended so the borrow appears there.
   function automatic logic [P_W:0] post_add(
      input logic           sub,
      input logic [P_W-1:0] z,
      input logic [P_W-1:0] x,
      input logic           cin
   );
      logic [P_W:0] x_plus_cin;
      x_plus_cin = {1'b0, x} + {{P_W{1'b0}}, cin};
      if (sub) begin
         return {1'b0, z} - x_plus_cin;
      end
      return {1'b0, z} + x_plus_cin;
   endfunction

endpackage

// File: rtl/dsp48a1_pipe_reg.sv
// rtl/dsp48a1_pipe_reg.sv - optional pipeline register with clock enable and async reset
//
// Purpose: one DSP48A1 pipeline stage that is either a register or a wire.
// Parameters:
//   REGISTER  1 = registered stage, 0 = combinational bypass
//   WIDTH     data width
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset, clears the register
//   ce_i   clock enable; register holds when low
//   d_i    stage input
//   q_o    stage output
module dsp48a1_pipe_reg #(
   parameter int REGISTER = 1,
   parameter int WIDTH    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (REGISTER != 0) begin : g_reg
         logic [WIDTH-1:0] data_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_q <= '0;
            end else if (ce_i) begin
               data_q <= d_i;
            end
         end

         assign q_o = data_q;
      end else begin : g_bypass
         // Clock, reset and enable have no effect on a bypassed stage.
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, clk, rst, ce_i};
         assign q_o         = d_i;
      end
   endgenerate

endmodule

// File: rtl/dsp48a1_post_adder.sv
// rtl/dsp48a1_post_adder.sv - DSP48A1 post-adder/accumulator with P and CARRYOUT registers
//
// Purpose: selects X and Z operands, adds or subtracts them with carry-in and
// registers the result into P / CARRYOUT; P feedback provides multiply-accumulate.
// Parameters:
//   OPMODEREG, CARRYINREG, CARRYOUTREG, PREG   1 = stage registered, 0 = bypassed
//   CARRYINSEL                                 "OPMODE5" or "CARRYIN"
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   opmode[7:0]                       X sel [1:0], Z sel [3:2], carry [5], subtract [7]
//   ce_opmode, ce_carryin, ce_p       register enables (ce_p also gates CARRYOUT)
//   m[35:0]                           registered multiplier product
//   dab[47:0]                         {D[11:0], A[17:0], B[17:0]}
//   c[47:0], pcin[47:0]               C operand, cascade input
//   carryin                           external carry-in
//   p, pcout                          result and its cascade copy
//   carryout, carryoutf               carry/borrow out and its fabric copy
module dsp48a1_post_adder
   import dsp48a1_pkg::*;
#(
   parameter int    OPMODEREG   = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CARRYOUTREG = 1,
   parameter int    PREG        = 1,
   parameter string CARRYINSEL  = "OPMODE5"
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [7:0]     opmode,
   input  logic           ce_opmode,
   input  logic           ce_carryin,
   input  logic           ce_p,
   input  logic [M_W-1:0] m,
   input  logic [P_W-1:0] dab,
   input  logic [P_W-1:0] c,
   input  logic [P_W-1:0] pcin,
   input  logic           carryin,
   output logic [P_W-1:0] p,
   output logic [P_W-1:0] pcout,
   output logic           carryout,
   output logic           carryoutf
);

   logic [7:0]     opmode_q;
   logic           cin_d;
   logic           cin_q;
   logic [P_W-1:0] p_fb;
   logic [P_W-1:0] x_mux;
   logic [P_W-1:0] z_mux;
   logic [P_W:0]   r_d;

   // Bits 4 and 6 drive the pre-adder; carryin is unused when OPMODE5 is the source.
   logic unused_in;
   assign unused_in = &{1'b0, opmode[4], opmode[6], opmode_q[4], opmode_q[6], carryin};

   generate
      if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
         assign cin_d = opmode[OP_CIN];
      end else if (CARRYINSEL == "CARRYIN") begin : g_cin_ext
         assign cin_d = carryin;
      end else begin : g_cin_bad
         $error("dsp48a1_post_adder: CARRYINSEL must be \"OPMODE5\" or \"CARRYIN\"");
         assign cin_d = 1'b0;
      end

      // Without a P register, P feedback would be a combinational loop; the
      // X/Z = P selections are illegal then, so they simply read zero.
      if (PREG != 0) begin : g_fb
         assign p_fb = p;
      end else begin : g_no_fb
         assign p_fb = '0;
      end
   endgenerate

   dsp48a1_pipe_reg #(.REGISTER(OPMODEREG), .WIDTH(8)) u_opmode_reg (
      .clk  (clk),
      .rst  (rst),
      .ce_i (ce_opmode),
      .d_i  (opmode),
      .q_o  (opmode_q)
   );

   dsp48a1_pipe_reg #(.REGISTER(CARRYINREG), .WIDTH(1)) u_cyi_reg (
      .clk  (clk),
      .rst  (rst),
      .ce_i (ce_carryin),
      .d_i  (cin_d),
      .q_o  (cin_q)
   );

   always_comb begin
      x_mux = '0;
      unique case (x_sel_e'(opmode_q[OP_X_LSB +: 2]))
         X_ZERO: x_mux = '0;
         X_M:    x_mux = {{(P_W - M_W){1'b0}}, m};
         X_P:    x_mux = p_fb;
         X_DAB:  x_mux = dab;
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      unique case (z_sel_e'(opmode_q[OP_Z_LSB +: 2]))
         Z_ZERO: z_mux = '0;
         Z_PCIN: z_mux = pcin;
         Z_P:    z_mux = p_fb;
         Z_C:    z_mux = c;
         default: z_mux = '0;
      endcase
   end

   assign r_d = post_add(opmode_q[OP_SUB], z_mux, x_mux, cin_q);

   dsp48a1_pipe_reg #(.REGISTER(PREG), .WIDTH(P_W)) u_p_reg (
      .clk  (clk),
      .rst  (rst),
      .ce_i (ce_p),
      .d_i  (r_d[P_W-1:0]),
      .q_o  (p)
   );

   dsp48a1_pipe_reg #(.REGISTER(CARRYOUTREG), .WIDTH(1)) u_carryout_reg (
      .clk  (clk),
      .rst  (rst),
      .ce_i (ce_p),
      .d_i  (r_d[P_W]),
      .q_o  (carryout)
   );

   assign pcout     = p;
   assign carryoutf = carryout;

endmodule
